// File: rtl/amsat_cfg_pkg.sv
// Shared definitions for the logic-analyzer configuration bank.
//   state_t    : commit FSM states (IDLE, COMMIT, DONE)
//   SYNC_DEPTH : number of synchronizer flops in front of each strobe edge detector
package amsat_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/amsat_sync_edge.sv
// Strobe conditioner: SYNC_DEPTH-flop synchronizer followed by a registered
// rising-edge detector. An input edge produces a one-cycle pulse three
// clocks later.
// Ports:
//   clk   in  sole clock
//   rst_n in  synchronous active-low reset
//   din   in  asynchronous level strobe
//   pulse out one-cycle pulse per rising edge of din
module amsat_sync_edge
  import amsat_cfg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [SYNC_DEPTH-1:0] sync_reg;
  logic                  level_d_reg;
  logic                  pulse_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg    <= '0;
      level_d_reg <= 1'b0;
      pulse_reg   <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_DEPTH-2:0], din};
      level_d_reg <= sync_reg[SYNC_DEPTH-1];
      pulse_reg   <= sync_reg[SYNC_DEPTH-1] & ~level_d_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/amsat_la_cfg_bank.sv
// Double-buffered analog configuration bank driven from logic-analyzer bits.
// Writes land in a staging word per channel; a commit copies staging to the
// active words one channel per cycle, so cfg_o only ever changes one channel
// at a time while busy_o is high.
// Ports:
//   wb_clk_i     in  sole clock
//   wb_rst_ni    in  synchronous active-low reset
//   la_wdata_i   in  write data (sampled in the write pulse cycle)
//   la_addr_i    in  target channel (sampled in the write pulse cycle)
//   la_wr_i      in  write strobe level, rising edge requests a write
//   la_commit_i  in  commit strobe level, rising edge requests a commit
//   cfg_o        out active configuration, channel k at [k*CFG_W +: CFG_W]
//   busy_o       out high while copying staging to active
//   cfg_update_o out one-cycle pulse when a commit completes
//   err_o        out sticky error (bad address or write while committing)
// Optional build macro AMSAT_CFG_READBACK_EN adds:
//   la_rsel_i    in  staging readback select
//   rdata_o      out registered staging[la_rsel_i], 0 when out of range
module amsat_la_cfg_bank
  import amsat_cfg_pkg::*;
#(
  parameter int               NUM_CH  = 4,
  parameter int               CFG_W   = 16,
  parameter int               ADDR_W  = 2,
  parameter logic [CFG_W-1:0] RST_CFG = '0
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic [CFG_W-1:0]        la_wdata_i,
  input  logic [ADDR_W-1:0]       la_addr_i,
  input  logic                    la_wr_i,
  input  logic                    la_commit_i,
`ifdef AMSAT_CFG_READBACK_EN
  input  logic [ADDR_W-1:0]       la_rsel_i,
  output logic [CFG_W-1:0]        rdata_o,
`endif
  output logic [NUM_CH*CFG_W-1:0] cfg_o,
  output logic                    busy_o,
  output logic                    cfg_update_o,
  output logic                    err_o
);

  localparam logic [ADDR_W:0]   NUM_CH_EXT = (ADDR_W+1)'(NUM_CH);
  localparam logic [ADDR_W-1:0] LAST_CH    = ADDR_W'(NUM_CH - 1);

  logic wr_pulse;
  logic commit_pulse;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              err_reg, err_next;

  logic [CFG_W-1:0] staging_reg [NUM_CH];
  logic [CFG_W-1:0] active_reg  [NUM_CH];

  logic addr_ok;
  logic wr_accept;
  logic wr_error;
  logic commit_start;

  amsat_sync_edge u_wr_edge (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .din   (la_wr_i),
    .pulse (wr_pulse)
  );

  amsat_sync_edge u_commit_edge (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .din   (la_commit_i),
    .pulse (commit_pulse)
  );

  // Writes are only accepted while idle and in range; anything else is an error.
  assign addr_ok      = ({1'b0, la_addr_i} < NUM_CH_EXT);
  assign wr_accept    = wr_pulse && (state_reg == IDLE) && addr_ok;
  assign wr_error     = wr_pulse && !((state_reg == IDLE) && addr_ok);
  assign commit_start = commit_pulse && (state_reg == IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    busy_o       = 1'b0;
    cfg_update_o = 1'b0;
    case (state_reg)
      IDLE: begin
        if (commit_start) begin
          state_next = COMMIT;
          cnt_next   = '0;
        end
      end
      COMMIT: begin
        busy_o = 1'b1;
        if (cnt_reg == LAST_CH) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        cfg_update_o = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // Entering COMMIT clears the flag, but a write error in the same cycle wins.
    if (commit_start) err_next = 1'b0;
    if (wr_error)     err_next = 1'b1;
  end

  assign err_o = err_reg;

  // A write accepted in the commit-start cycle lands before channel 0 is
  // copied, so the commit always includes it.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        staging_reg[i] <= RST_CFG;
        active_reg[i]  <= RST_CFG;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_accept && (la_addr_i == ADDR_W'(i)))
          staging_reg[i] <= la_wdata_i;
        if ((state_reg == COMMIT) && (cnt_reg == ADDR_W'(i)))
          active_reg[i] <= staging_reg[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cfg
      assign cfg_o[gi*CFG_W +: CFG_W] = active_reg[gi];
    end
  endgenerate

`ifdef AMSAT_CFG_READBACK_EN
  logic [CFG_W-1:0] rd_mux;
  logic [CFG_W-1:0] rdata_reg;

  // Out-of-range selects match no channel and read back as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (la_rsel_i == ADDR_W'(i))
        rd_mux = staging_reg[i];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) rdata_reg <= '0;
    else            rdata_reg <= rd_mux;
  end

  assign rdata_o = rdata_reg;
`endif

endmodule
